alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Handshake and result bundle between a requester and the sequential 8-bit ALU.
// The flags-register feedback (carry_flag_in) travels with the request.
interface alu_seq_if;
    logic       start;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       carry_flag_in;
    logic       busy;
    logic       done;
    logic [7:0] alu_result;
    logic       carry_out;
    logic       overflow_out;
    logic       update_flags;
    logic       write_en;

    modport master (
        output start, op, a, b, carry_flag_in,
        input  busy, done, alu_result, carry_out, overflow_out, update_flags, write_en
    );

    modport slave (
        input  start, op, a, b, carry_flag_in,
        output busy, done, alu_result, carry_out, overflow_out, update_flags, write_en
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential 8-bit ALU: single-cycle arithmetic/logic ops, one-bit-per-clock shifts,
// registered results and flags that hold between operations.
module alu_seq (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_CMP = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_SAR = 4'd10;
    localparam logic [3:0] OP_ROL = 4'd11;
    localparam logic [3:0] OP_ROR = 4'd12;

    state_t     state_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       update_flags_reg;
    logic       write_en_reg;
    logic [7:0] alu_result_reg;
    logic       carry_reg;
    logic       overflow_reg;
    logic [7:0] shift_reg;
    logic [2:0] count_reg;
    logic [3:0] shift_op_reg;

    // Single-cycle datapath for the non-shift ops
    logic [8:0] sum_next;
    logic [8:0] diff_next;
    logic [7:0] result_next;
    logic       carry_next;
    logic       overflow_next;
    logic       legal_next;
    logic       is_shift;
    logic       carry_add;
    logic       borrow_sub;

    always_comb begin
        carry_add     = (bus.op == OP_ADC) & bus.carry_flag_in;
        borrow_sub    = (bus.op == OP_SBB) & bus.carry_flag_in;
        sum_next      = {1'b0, bus.a} + {1'b0, bus.b} + {8'd0, carry_add};
        diff_next     = {1'b0, bus.a} - {1'b0, bus.b} - {8'd0, borrow_sub};
        result_next   = 8'h00;
        carry_next    = 1'b0;
        overflow_next = 1'b0;
        legal_next    = 1'b1;
        is_shift      = 1'b0;
        case (bus.op)
            OP_ADD, OP_ADC: begin
                result_next   = sum_next[7:0];
                carry_next    = sum_next[8];
                overflow_next = (bus.a[7] == bus.b[7]) && (sum_next[7] != bus.a[7]);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                result_next   = diff_next[7:0];
                carry_next    = diff_next[8];
                overflow_next = (bus.a[7] != bus.b[7]) && (diff_next[7] != bus.a[7]);
            end
            OP_AND: result_next = bus.a & bus.b;
            OP_OR:  result_next = bus.a | bus.b;
            OP_XOR: result_next = bus.a ^ bus.b;
            OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: is_shift = 1'b1;
            default: legal_next = 1'b0;
        endcase
    end

    // One shift step: each bit takes its neighbour, ends take the op-specific fill
    logic       dir_left;
    logic       fill_left;
    logic       fill_right;
    logic [7:0] from_left;
    logic [7:0] from_right;
    logic [7:0] step_val;
    logic       step_cf;
    logic       step_of;

    assign dir_left   = (shift_op_reg == OP_SHL) || (shift_op_reg == OP_ROL);
    assign fill_left  = (shift_op_reg == OP_ROL) ? shift_reg[7] : 1'b0;
    assign fill_right = (shift_op_reg == OP_SAR) ? shift_reg[7] :
                        (shift_op_reg == OP_ROR) ? shift_reg[0] : 1'b0;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign from_left[gi] = fill_left;
            end else begin : g_mid_l
                assign from_left[gi] = shift_reg[gi-1];
            end
            if (gi == 7) begin : g_msb
                assign from_right[gi] = fill_right;
            end else begin : g_mid_r
                assign from_right[gi] = shift_reg[gi+1];
            end
            assign step_val[gi] = dir_left ? from_left[gi] : from_right[gi];
        end
    endgenerate

    assign step_cf = dir_left ? shift_reg[7] : shift_reg[0];

    always_comb begin
        case (shift_op_reg)
            OP_SHL, OP_ROL: step_of = step_val[7] ^ step_cf;
            OP_SHR:         step_of = shift_reg[7];
            OP_ROR:         step_of = step_val[7] ^ step_val[6];
            default:        step_of = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            update_flags_reg <= 1'b0;
            write_en_reg     <= 1'b0;
            alu_result_reg   <= 8'h00;
            carry_reg        <= 1'b0;
            overflow_reg     <= 1'b0;
            shift_reg        <= 8'h00;
            count_reg        <= 3'd0;
            shift_op_reg     <= 4'd0;
        end else begin
            done_reg         <= 1'b0;
            update_flags_reg <= 1'b0;
            write_en_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        if (is_shift && bus.b[2:0] == 3'd0) begin
                            // Zero count: pass a through, flags untouched
                            alu_result_reg <= bus.a;
                            done_reg       <= 1'b1;
                            state_reg      <= DONE;
                        end else if (is_shift) begin
                            shift_reg    <= bus.a;
                            count_reg    <= bus.b[2:0];
                            shift_op_reg <= bus.op;
                            busy_reg     <= 1'b1;
                            state_reg    <= SHIFT;
                        end else if (legal_next) begin
                            alu_result_reg   <= result_next;
                            carry_reg        <= carry_next;
                            overflow_reg     <= overflow_next;
                            update_flags_reg <= 1'b1;
                            write_en_reg     <= (bus.op != OP_CMP);
                            done_reg         <= 1'b1;
                            state_reg        <= DONE;
                        end else begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    shift_reg <= step_val;
                    count_reg <= count_reg - 3'd1;
                    if (count_reg == 3'd1) begin
                        alu_result_reg   <= step_val;
                        carry_reg        <= step_cf;
                        overflow_reg     <= step_of;
                        busy_reg         <= 1'b0;
                        done_reg         <= 1'b1;
                        update_flags_reg <= 1'b1;
                        write_en_reg     <= 1'b1;
                        state_reg        <= DONE;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
    assign bus.update_flags = update_flags_reg;
    assign bus.write_en     = write_en_reg;
    assign bus.alu_result   = alu_result_reg;
    assign bus.carry_out    = carry_reg;
    assign bus.overflow_out = overflow_reg;
endmodule
